obstacle_spawner: RTL

Decides when and where a new obstacle enters the playfield and feeds the obstacle controller. It produces a one-cycle typed trigger (`obstacle_trigger`) and a held horizontal start column (`obstacle_start_x`). Spawns are paced in video frames, and the spawn interval shrinks as the game progresses. A 16-bit LFSR randomises the start column and the obstacle type. The block sits between the game-state logic (`enable`, `frame_tick`) and the obstacle controller (`obstacle_busy`).

---
 rtl/obstacle_spawner.sv | 85 ++++++++
 1 files changed

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: paces obstacle spawns in video frames with a shrinking interval,
// randomising start column and obstacle type from a 16-bit LFSR.
module obstacle_spawner #(
   parameter int          SCREEN_W     = 640,
   parameter int          OBST_W       = 32,
   parameter int          SPAWN_FRAMES = 60,
   parameter int          MIN_FRAMES   = 15,
   parameter int          DIFF_STEP    = 8,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic       obstacle_busy,
   output logic [1:0] obstacle_trigger,
   output logic [9:0] obstacle_start_x,
   output logic [7:0] interval
);
   localparam logic [9:0] MAX_X      = 10'(SCREEN_W - OBST_W);
   localparam logic [7:0] INIT_INT   = 8'(SPAWN_FRAMES);
   localparam logic [7:0] MIN_INT    = 8'(MIN_FRAMES);
   localparam logic [7:0] LAST_SPAWN = 8'(DIFF_STEP - 1);
   typedef enum logic [1:0] {IDLE, WAIT, ARM, FIRE} state_t;
   state_t      r_state, w_next;
   logic [15:0] r_lfsr;
   logic [7:0]  r_frame_cnt, r_spawn_cnt, r_interval;
   logic [1:0]  r_trigger, w_type;
   logic [9:0]  r_start_x, w_col, w_start_x;
   logic        w_last_tick, w_step_up;
   assign w_col       = r_lfsr[9:0];
   // a single fold is enough: the largest raw column minus (MAX_X+1) stays in range
   assign w_start_x   = (w_col <= MAX_X) ? w_col : w_col - (MAX_X + 10'd1);
   assign w_type      = (r_lfsr[11:10] == 2'b00) ? 2'b01 : r_lfsr[11:10];
   assign w_last_tick = frame_tick && (r_frame_cnt == r_interval - 8'd1);
   assign w_step_up   = (r_spawn_cnt == LAST_SPAWN);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = WAIT;
         WAIT:    w_next = w_last_tick ? ARM : WAIT;
         ARM:     w_next = obstacle_busy ? ARM : FIRE;
         FIRE:    w_next = WAIT;
         default: w_next = IDLE;
      endcase
      if (!enable) w_next = IDLE;
   end
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state     <= IDLE;
         r_lfsr      <= SEED;
         r_frame_cnt <= '0;
         r_spawn_cnt <= '0;
         r_interval  <= INIT_INT;
         r_trigger   <= '0;
         r_start_x   <= '0;
      end else begin
         r_state <= w_next;
         r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         if (!enable) begin
            r_trigger   <= '0;
            r_frame_cnt <= '0;
         end else begin
            case (r_state)
               IDLE: r_frame_cnt <= '0;
               WAIT: if (frame_tick) r_frame_cnt <= r_frame_cnt + 8'd1;
               ARM: if (!obstacle_busy) begin
                  r_start_x <= w_start_x;
                  r_trigger <= w_type;
               end
               FIRE: begin
                  r_trigger   <= '0;
                  r_frame_cnt <= '0;
                  r_spawn_cnt <= w_step_up ? 8'd0 : r_spawn_cnt + 8'd1;
                  if (w_step_up && r_interval > MIN_INT) r_interval <= r_interval - 8'd1;
               end
               default: ;
            endcase
         end
      end
   end
   assign obstacle_trigger = r_trigger;
   assign obstacle_start_x = r_start_x;
   assign interval         = r_interval;
endmodule
